// File: rtl/act_skew_feeder_pkg.sv
// Shared constants, element type and FSM encoding for the activation skew feeder.
package act_skew_feeder_pkg;

    localparam int ARRAY_SIZE         = 8;
    localparam int COMPUTE_DATA_WIDTH = 4;
    localparam int BUFFER_WORD_SIZE   = 16;
    localparam int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH;
    localparam int WORDS_PER_VEC      = ARRAY_SIZE / NUM_COMPUTE_LANES;
    localparam int VEC_CNT_WIDTH      = 8;
    localparam int DRAIN_CYCLES       = 2 * ARRAY_SIZE - 2;
    localparam int STALL_CNT_WIDTH    = 16;

    typedef logic signed [COMPUTE_DATA_WIDTH-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (v == {STALL_CNT_WIDTH{1'b1}}) ? v : v + STALL_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/act_skew_feeder_skew_shift_line.sv
// One row of the diagonal skew: a DEPTH-deep shift register that moves only on shift.
module skew_shift_line
    import act_skew_feeder_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = COMPUTE_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] line_q [DEPTH];

    // Advance one position per shift; holding on stalls keeps rows aligned with the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                line_q[j] <= '0;
            end
        end else if (shift) begin
            line_q[0] <= d;
            for (int j = 1; j < DEPTH; j++) begin
                line_q[j] <= line_q[j-1];
            end
        end
    end

    assign q = line_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Unpacks buffer words into activation vectors and feeds them diagonally skewed to the PE array.
// Optional build macro ACT_FEEDER_STALL_CNT_EN adds the stall_cycles counter output.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [VEC_CNT_WIDTH-1:0]    num_vecs,
    input  logic [BUFFER_WORD_SIZE-1:0] word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output act_t                        ins [ARRAY_SIZE],
    output logic                        compute,
    output logic                        busy,
    output logic                        done
`ifdef ACT_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0]  stall_cycles
`endif
);

    localparam int WORD_CNT_W  = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
    localparam int DRAIN_CNT_W = $clog2(DRAIN_CYCLES);
    localparam logic [WORD_CNT_W-1:0]  LAST_WORD  = WORD_CNT_W'(WORDS_PER_VEC - 1);
    localparam logic [DRAIN_CNT_W-1:0] LAST_DRAIN = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    feeder_state_t            state_q, state_d;
    logic [VEC_CNT_WIDTH-1:0] num_vecs_q, num_vecs_d;
    logic [VEC_CNT_WIDTH-1:0] vec_asm_q, vec_asm_d;
    logic [VEC_CNT_WIDTH-1:0] vec_iss_q, vec_iss_d;
    logic [WORD_CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [DRAIN_CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                     stage_full_q, stage_full_d;
    act_t                     stage_q [ARRAY_SIZE];
    act_t                     stage_d [ARRAY_SIZE];
    act_t                     skew_in_s [ARRAY_SIZE];
    logic                     compute_q, busy_q, done_q;
    logic                     issue_s, word_ready_s, accept_s, vec_done_s, advance_s;

    // Handshake and advance qualifiers, all from registered state.
    always_comb begin
        issue_s      = (state_q == STREAM) && stage_full_q;
        word_ready_s = (state_q == STREAM) && (!stage_full_q || issue_s) && (vec_asm_q < num_vecs_q);
        accept_s     = word_valid && word_ready_s;
        vec_done_s   = accept_s && (word_cnt_q == LAST_WORD);
        advance_s    = issue_s || (state_q == DRAIN);
    end

    // The old staged vector is sampled by the skew lines on the same edge a new word overwrites it.
    always_comb begin
        for (int w = 0; w < WORDS_PER_VEC; w++) begin
            for (int k = 0; k < NUM_COMPUTE_LANES; k++) begin
                stage_d[w*NUM_COMPUTE_LANES + k] =
                    (accept_s && (word_cnt_q == WORD_CNT_W'(w)))
                    ? act_t'(word_in[k*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH])
                    : stage_q[w*NUM_COMPUTE_LANES + k];
            end
        end
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            skew_in_s[i] = (state_q == DRAIN) ? act_t'(0) : stage_q[i];
        end
    end

    // Job sequencing: next state and counters.
    always_comb begin
        state_d      = state_q;
        num_vecs_d   = num_vecs_q;
        vec_asm_d    = vec_asm_q;
        vec_iss_d    = vec_iss_q;
        word_cnt_d   = word_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        stage_full_d = stage_full_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_asm_d    = '0;
                    vec_iss_d    = '0;
                    word_cnt_d   = '0;
                    stage_full_d = 1'b0;
                    if (num_vecs == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = STREAM;
                        num_vecs_d = num_vecs;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (accept_s) begin
                    word_cnt_d = vec_done_s ? '0 : word_cnt_q + WORD_CNT_W'(1);
                    vec_asm_d  = vec_done_s ? vec_asm_q + VEC_CNT_WIDTH'(1) : vec_asm_q;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
                if (vec_done_s) begin
                    stage_full_d = 1'b1;
                end else if (issue_s) begin
                    stage_full_d = 1'b0;
                end else begin
                    stage_full_d = stage_full_q;
                end
                if (issue_s) begin
                    vec_iss_d = vec_iss_q + VEC_CNT_WIDTH'(1);
                    if (vec_iss_q == num_vecs_q - VEC_CNT_WIDTH'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    vec_iss_d = vec_iss_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and staging registers; status outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_vecs_q   <= '0;
            vec_asm_q    <= '0;
            vec_iss_q    <= '0;
            word_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            stage_full_q <= 1'b0;
            compute_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            num_vecs_q   <= num_vecs_d;
            vec_asm_q    <= vec_asm_d;
            vec_iss_q    <= vec_iss_d;
            word_cnt_q   <= word_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            stage_full_q <= stage_full_d;
            compute_q    <= advance_s;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
        skew_shift_line #(
            .DEPTH(i + 1),
            .WIDTH(COMPUTE_DATA_WIDTH)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .shift (advance_s),
            .d     (skew_in_s[i]),
            .q     (ins[i])
        );
    end

`ifdef ACT_FEEDER_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    // Stream cycles without an advance; value is kept after the job ends.
    always_comb begin
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && !advance_s) begin
            stall_d = sat_inc(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign word_ready = word_ready_s;
    assign compute    = compute_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Activation feeder directly upstream of the systolic PE array.
- Unpacks buffer words into ARRAY_SIZE-element activation vectors and applies diagonal skew: row i delayed by i advance steps.
- Drives the array's per-row ins inputs and its global compute enable, then drains the pipeline and signals completion.

Parameters:
- ARRAY_SIZE, 8, PE array rows/cols; must be a multiple of NUM_COMPUTE_LANES.
- COMPUTE_DATA_WIDTH, 4, signed activation element width.
- BUFFER_WORD_SIZE, 16, input word width.
- NUM_COMPUTE_LANES, BUFFER_WORD_SIZE/COMPUTE_DATA_WIDTH (4), elements per word.
- WORDS_PER_VEC, ARRAY_SIZE/NUM_COMPUTE_LANES (2), words per vector.
- VEC_CNT_WIDTH, 8, width of the vector count.
- DRAIN_CYCLES, 2*ARRAY_SIZE-2 (14), zero-fed compute cycles after the last vector.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a job; sampled only in IDLE
- num_vecs  in  VEC_CNT_WIDTH  vectors in the job; latched on start
- word_in  in  BUFFER_WORD_SIZE  packed activations; lane k in bits [k*CDW +: CDW]
- word_valid  in  1  word_in valid
- word_ready  out  1  feeder accepts word_in this cycle
- ins  out  signed CDW x [ARRAY_SIZE]  skewed activations to the array rows
- compute  out  1  array advance enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: all outputs 0, all skew registers 0, staging register cleared, FSM in IDLE.
- A word is accepted when word_valid && word_ready are both high on a clock edge.
- FSM states:
  - IDLE: start with num_vecs==0 -> DONE. start with num_vecs>0 -> latch num_vecs, go to STREAM. Start is ignored in all other states.
  - STREAM: assembles vectors and issues them (rules below). After the issue of vector num_vecs-1 -> DRAIN.
  - DRAIN: issues an all-zero vector every cycle for exactly DRAIN_CYCLES cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Assembly:
  - Word w of a vector fills elements w*NUM_COMPUTE_LANES+k, for lanes k = 0..NUM_COMPUTE_LANES-1.
  - After WORDS_PER_VEC accepted words, stage_full is set.
- Issue (advance):
  - Occurs on any STREAM edge where stage_full=1.
  - Issue shifts every skew line by one position. Element i of the staged vector enters row i's line.
  - Issue clears stage_full, unless the same edge completes a new vector.
- word_ready = (state==STREAM) && (!stage_full || issuing) && (vectors assembled < num_vecs). It is combinational from registered state.
- Stalls: if no full vector is staged, nothing shifts and compute stays 0 that cycle. The array and the skew stay coherent.
- Skew:
  - Row i has i+1 registers; ins[i] is the last register of row i.
  - compute is registered: high in the cycle after each advance, when the newly shifted ins are present.
  - Element i of vector v appears on ins[i] after v's (i+1)-th advance.
- Element values are passed through unmodified, with no sign or width change.
- Synchronous rst in any state aborts the job and restores the reset values on the next edge. A partial word count is discarded.

Optional Feature:
- Macro: ACT_FEEDER_STALL_CNT_EN.
- Defined: adds output stall_cycles (16 bit). It clears on start and increments, saturating at 0xFFFF, on every STREAM cycle without an advance. It holds its value after done.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - ARRAY_SIZE, COMPUTE_DATA_WIDTH and BUFFER_WORD_SIZE constants;
  - the act_t signed element typedef;
  - the feeder_state_t enum (IDLE, STREAM, DRAIN, DONE).
- Sub-module skew_shift_line(DEPTH, WIDTH, clk, rst, shift, d, q) is instantiated once per row with DEPTH=i+1.

Test Plan:
- Single vector:
  - Stimulus: num_vecs=1; words 0x4321 then 0x8765 with word_valid always high.
  - Response: ins[0]=1 the cycle after the issue; ins[7]=8 seven advances later; exactly 15 compute cycles; done pulses once; busy drops the next cycle.
- Back-pressure and stall:
  - Stimulus: num_vecs=2; word_valid low for 3 cycles between words.
  - Response: compute stays 0 during the gap; the skewed diagonal is still intact (ins[i] shows vector0 element i exactly i advances after ins[0]).
- Zero job:
  - Stimulus: start with num_vecs=0.
  - Response: done in the 2nd cycle, compute never asserted, word_ready never asserted.
- Reset mid-job:
  - Stimulus: assert rst during DRAIN of a 4-vector job.
  - Response: next cycle all ins=0, compute=0, busy=0; a new job with num_vecs=1 then runs correctly.
- Sign and throughput:
  - Stimulus: words 0xF8F8 x4 for num_vecs=2.
  - Response: ins elements read -8 and -1; word_ready holds 1 so one vector issues every WORDS_PER_VEC cycles.
- Stall counter (ACT_FEEDER_STALL_CNT_EN defined):
  - Stimulus: the back-pressure scenario above.
  - Response: stall_cycles equals the count of STREAM cycles with no advance.
